// File: rtl/button_enable_ctrl.sv
// -----------------------------------------------------------------------------
// button_enable_ctrl
//   Turns a raw, bouncy push-button into a clean enable level for the
//   breathing-LED stage. A short press toggles the enable, a long press forces
//   it off, and an optional idle timeout switches it off automatically.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous reset, active low
//   btn_in       in   raw button, active high, asynchronous to clk
//   enable_out   out  registered enable level to the LED stage
//   press_pulse  out  one-cycle strobe: short press accepted
//   long_pulse   out  one-cycle strobe: long press detected
//   btn_state    out  debounced button level
// -----------------------------------------------------------------------------
module button_enable_ctrl #(
  parameter int unsigned CLK_FREQ    = 1_000_000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned TIMEOUT_S   = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic enable_out,
  output logic press_pulse,
  output logic long_pulse,
  output logic btn_state
);

  localparam int unsigned DB_CYC   = (CLK_FREQ / 1000) * DEBOUNCE_MS;
  localparam int unsigned LONG_CYC = (CLK_FREQ / 1000) * LONG_MS;
  localparam int unsigned TO_CYC   = CLK_FREQ * TIMEOUT_S;
  localparam bit          TO_EN    = (TIMEOUT_S != 0);
  // Keeps the timeout counter at a legal width when the timeout is disabled.
  localparam int unsigned TO_TERM  = TO_EN ? TO_CYC : 1;

  localparam int unsigned DB_W   = $clog2(DB_CYC + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);
  localparam int unsigned TO_W   = $clog2(TO_TERM + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_LONG    = 2'd2
  } state_e;

  logic              sync1_q, sync2_q;
  logic              btn_state_q, btn_state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [DB_W-1:0]   arm_cnt_q, arm_cnt_d;
  logic              armed_q, armed_d;
  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              enable_q, enable_d;
  logic              press_q, press_d;
  logic              long_q, long_d;

  logic flip_c, rise_c, fall_c, start_c, to_run_c, to_fire_c;

  // Debounce: flip the clean level after DB_CYC consecutive disagreeing cycles.
  always_comb begin
    btn_state_d = btn_state_q;
    db_cnt_d    = '0;
    flip_c      = 1'b0;
    if (sync2_q != btn_state_q) begin
      if (db_cnt_q == DB_W'(DB_CYC - 1)) begin
        flip_c      = 1'b1;
        btn_state_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign rise_c = flip_c & sync2_q;
  assign fall_c = flip_c & ~sync2_q;

  // Arming: after reset the button must be seen released for a full debounce
  // window before a press is accepted, so a press held through reset is ignored.
  always_comb begin
    arm_cnt_d = arm_cnt_q;
    armed_d   = armed_q;
    if (!armed_q) begin
      if (sync2_q) begin
        arm_cnt_d = '0;
      end else if (arm_cnt_q == DB_W'(DB_CYC - 1)) begin
        armed_d   = 1'b1;
        arm_cnt_d = '0;
      end else begin
        arm_cnt_d = arm_cnt_q + DB_W'(1);
      end
    end
  end

  assign start_c = rise_c & armed_q;

  // Idle timeout: runs only while enabled and idle; a press start clears it.
  assign to_run_c  = TO_EN && (state_q == S_IDLE) && enable_q && !start_c;
  assign to_fire_c = to_run_c && (to_cnt_q == TO_W'(TO_TERM - 1));

  always_comb begin
    to_cnt_d = '0;
    if (to_run_c && !to_fire_c) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // Press FSM: next state, hold counter, enable level and strobes.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    enable_d   = enable_q;
    press_d    = 1'b0;
    long_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_c) begin
          state_d    = S_PRESSED;
          hold_cnt_d = '0;
        end else if (to_fire_c) begin
          enable_d = 1'b0;
        end
      end
      S_PRESSED: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (hold_cnt_q == HOLD_W'(LONG_CYC - 1)) begin
          // Long press wins over a simultaneous release; skip LONG if already released.
          long_d   = 1'b1;
          enable_d = 1'b0;
          state_d  = fall_c ? S_IDLE : S_LONG;
        end else if (fall_c) begin
          press_d  = 1'b1;
          enable_d = ~enable_q;
          state_d  = S_IDLE;
        end
      end
      S_LONG: begin
        if (fall_c) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      btn_state_q <= 1'b0;
      db_cnt_q    <= '0;
      arm_cnt_q   <= '0;
      armed_q     <= 1'b0;
      state_q     <= S_IDLE;
      hold_cnt_q  <= '0;
      to_cnt_q    <= '0;
      enable_q    <= 1'b0;
      press_q     <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync1_q     <= btn_in;
      sync2_q     <= sync1_q;
      btn_state_q <= btn_state_d;
      db_cnt_q    <= db_cnt_d;
      arm_cnt_q   <= arm_cnt_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      to_cnt_q    <= to_cnt_d;
      enable_q    <= enable_d;
      press_q     <= press_d;
      long_q      <= long_d;
    end
  end

  assign enable_out  = enable_q;
  assign press_pulse = press_q;
  assign long_pulse  = long_q;
  assign btn_state   = btn_state_q;

endmodule

// File: tb/tb_button_enable_ctrl.sv
// -----------------------------------------------------------------------------
// tb_button_enable_ctrl
//   Directed scenarios with a cycle-stamped event scoreboard. Stimulus pushes
//   expected output events (debounced edges, strobes, enable changes); a
//   monitor pops and compares whenever the DUT shows one. A second instance
//   built without timeout is exercised in parallel.
// -----------------------------------------------------------------------------
module tb_button_enable_ctrl;

  localparam int LAT  = 102;    // btn_in edge to btn_state edge
  localparam int LONG = 500;
  localparam int TO   = 10_000;

  localparam int K_BTN0  = 0;
  localparam int K_BTN1  = 1;
  localparam int K_PRESS = 2;
  localparam int K_LONG  = 3;
  localparam int K_EN0   = 4;
  localparam int K_EN1   = 5;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n, rst2_n, btn, btn2;
  logic en, pp, lp, bs;
  logic en2, pp2, lp2, bs2;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  bit   m_en = 1'b0;
  ev_t  sb_q[$];
  logic p_bs = 1'b0;
  logic p_en = 1'b0;

  button_enable_ctrl #(
    .CLK_FREQ(10_000), .DEBOUNCE_MS(10), .LONG_MS(50), .TIMEOUT_S(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn),
    .enable_out(en), .press_pulse(pp), .long_pulse(lp), .btn_state(bs)
  );

  button_enable_ctrl #(
    .CLK_FREQ(10_000), .DEBOUNCE_MS(10), .LONG_MS(50), .TIMEOUT_S(0)
  ) dut_noto (
    .clk(clk), .rst_n(rst2_n), .btn_in(btn2),
    .enable_out(en2), .press_pulse(pp2), .long_pulse(lp2), .btn_state(bs2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_BTN0:  return "btn_state_fall";
      K_BTN1:  return "btn_state_rise";
      K_PRESS: return "press_pulse";
      K_LONG:  return "long_pulse";
      K_EN0:   return "enable_fall";
      K_EN1:   return "enable_rise";
      default: return "unknown";
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c);
    ev_t e;
    e.cyc  = c;
    e.kind = kind;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input int kind);
    ev_t e;
    n_chk++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got %s at cycle %0d expected none", kname(kind), cyc);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        n_err++;
        $display("FAIL event_order: got %s at cycle %0d expected %s at cycle %0d",
                 kname(kind), cyc, kname(e.kind), e.cyc);
      end
    end
  endtask

  // Monitor: outputs sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bs !== p_bs) sb_check(bs ? K_BTN1 : K_BTN0);
      if (pp === 1'b1) sb_check(K_PRESS);
      if (lp === 1'b1) sb_check(K_LONG);
      if (en !== p_en) sb_check(en ? K_EN1 : K_EN0);
    end
    p_bs <= bs;
    p_en <= en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // One press of 'hold' cycles; pushes every expected event, returns release-edge cycle.
  task automatic do_press(input int hold, output int t_fall);
    int c0, r, f;
    tick();
    btn = 1'b1;
    c0 = cyc;
    r = c0 + LAT;
    f = c0 + hold + LAT;
    push(K_BTN1, r);
    if (f - r < LONG) begin
      push(K_BTN0, f);
      push(K_PRESS, f);
      push(m_en ? K_EN0 : K_EN1, f);
      m_en = !m_en;
    end else begin
      push(K_LONG, r + LONG);
      if (m_en) push(K_EN0, r + LONG);
      m_en = 1'b0;
      push(K_BTN0, f);
    end
    repeat (hold) tick();
    btn = 1'b0;
    t_fall = f;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 12_000) begin
      tick();
      n++;
    end
    chk(name, sb_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_enable"},    int'(en), 0);
    chk({tag, "_press"},     int'(pp), 0);
    chk({tag, "_long"},      int'(lp), 0);
    chk({tag, "_btn_state"}, int'(bs), 0);
  endtask

  // Watchdog: any hang ends the run with a failure and the summary.
  initial begin
    while (cyc < 95_000) @(posedge clk);
    n_chk++;
    n_err++;
    $display("FAIL watchdog: got cycle %0d expected completion before it", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    int t, t1, t2, c0, c1, r;
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    btn    = 1'b0;
    btn2   = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    repeat (200) tick();

    fork
      begin
        // Bounce: runs shorter than the debounce window never register.
        for (int i = 0; i < 15; i++) begin
          btn = ~btn;
          repeat (20) tick();
        end
        btn = 1'b0;
        repeat (250) tick();
        chk("bounce_btn_state", int'(bs), 0);
        chk("bounce_enable", int'(en), 0);
        drain("bounce_queue");

        // Short press on, short press off.
        do_press(300, t);
        drain("short1_queue");
        chk("short1_enable", int'(en), 1);
        repeat (100) tick();
        do_press(300, t);
        drain("short2_queue");
        chk("short2_enable", int'(en), 0);
        repeat (100) tick();

        // Long press while enabled forces off without toggling on release.
        do_press(300, t);
        drain("long_pre_queue");
        repeat (100) tick();
        do_press(800, t);
        drain("long_queue");
        chk("long_enable", int'(en), 0);
        repeat (100) tick();

        // Reset mid-press at hold_cnt = 250, button held through reset.
        tick();
        btn = 1'b1;
        c0 = cyc;
        push(K_BTN1, c0 + LAT);
        wait_until(c0 + LAT + 250);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (3) tick();
        rst_n = 1'b1;
        r = cyc;
        m_en = 1'b0;
        push(K_BTN1, r + LAT);
        repeat (200) tick();
        btn = 1'b0;
        c1 = cyc;
        push(K_BTN0, c1 + LAT);
        drain("postreset_release_queue");
        chk("postreset_enable", int'(en), 0);
        repeat (200) tick();
        do_press(300, t);
        drain("postreset_press_queue");
        chk("postreset_press_enable", int'(en), 1);
        repeat (100) tick();
        do_press(300, t);
        drain("postreset_off_queue");
        repeat (100) tick();

        // Timeout: a press spanning the original deadline holds the enable.
        do_press(300, t);
        wait_until(t + 9_499);
        do_press(450, t1);
        wait_until(t + 10_010);
        chk("timeout_held_by_press", int'(en), 1);
        drain("timeout_press_queue");
        repeat (250) tick();
        do_press(300, t2);
        push(K_EN0, t2 + TO);
        m_en = 1'b0;
        wait_until(t2 + TO - 1);
        chk("timeout_before_expiry", int'(en), 1);
        drain("timeout_queue");
        chk("timeout_enable", int'(en), 0);
      end
      begin
        // Build without timeout stays enabled indefinitely.
        tick();
        btn2 = 1'b1;
        c0 = cyc;
        repeat (300) tick();
        btn2 = 1'b0;
        wait_until(c0 + 300 + LAT - 1);
        chk("noto_enable_before", int'(en2), 0);
        tick();
        chk("noto_enable_on", int'(en2), 1);
        chk("noto_press_pulse", int'(pp2), 1);
        for (int i = 0; i < 50; i++) begin
          repeat (1000) tick();
          chk("noto_enable_hold", int'(en2), 1);
        end
        chk("noto_long", int'(lp2), 0);
        chk("noto_btn_state", int'(bs2), 0);
      end
    join

    repeat (10) tick();
    drain("final_queue");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
